// File: rtl/window_averager.sv
// Window averager: reads 2^LOG2_DEPTH samples from a synchronous-read buffer and reports mean/min/max.
// Optional round-half-up mean when WINDOW_AVERAGER_ROUND_EN is defined (truncating otherwise).
module window_averager #(
  parameter int WIDTH      = 25,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      rd_data,
  output logic                  rd_en,
  output logic [LOG2_DEPTH-1:0] rd_addr,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      avg,
  output logic [WIDTH-1:0]      min,
  output logic [WIDTH-1:0]      max
);

  localparam int ACC_W = WIDTH + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] LAST_ADDR = '1;
`ifdef WINDOW_AVERAGER_ROUND_EN
  localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (LOG2_DEPTH - 1);
`endif

  typedef enum logic [1:0] {IDLE, READ, LAST, OUT} state_t;

  state_t                  state_q, state_d;
  logic [LOG2_DEPTH-1:0]   cnt_q, cnt_d;
  logic                    vld_q;
  logic [ACC_W-1:0]        sum_q, sum_d;
  logic [WIDTH-1:0]        lo_q, lo_d;
  logic [WIDTH-1:0]        hi_q, hi_d;
  logic [WIDTH-1:0]        avg_q, min_q, max_q;

  // The accumulator cannot overflow: N samples of at most 2^WIDTH-1 fit in WIDTH+LOG2_DEPTH bits,
  // and adding half an LSB before the shift still stays within range.
  function automatic logic [WIDTH-1:0] mean_f(input logic [ACC_W-1:0] s);
`ifdef WINDOW_AVERAGER_ROUND_EN
    return WIDTH'((s + HALF) >> LOG2_DEPTH);
`else
    return WIDTH'(s >> LOG2_DEPTH);
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    // Buffer data is valid exactly one cycle after each read strobe.
    if (vld_q) begin
      sum_d = sum_q + ACC_W'(rd_data);
      if (rd_data < lo_q) lo_d = rd_data;
      if (rd_data > hi_q) hi_d = rd_data;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          cnt_d   = '0;
          sum_d   = '0;
          lo_d    = '1;
          hi_d    = '0;
        end
      end
      READ: begin
        if (cnt_q == LAST_ADDR) state_d = LAST;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      LAST:    state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      sum_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      avg_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= (state_q == READ);
      sum_q   <= sum_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      // Results are captured as LAST absorbs the final sample, so they are valid alongside done.
      if (state_q == LAST) begin
        avg_q <= mean_f(sum_d);
        min_q <= lo_d;
        max_q <= hi_d;
      end
    end
  end

  assign rd_en   = (state_q == READ);
  assign rd_addr = cnt_q;
  assign busy    = (state_q == READ) || (state_q == LAST);
  assign done    = (state_q == OUT);
  assign avg     = avg_q;
  assign min     = min_q;
  assign max     = max_q;

endmodule

// File: tb/tb_window_averager.sv
// Directed bench for window_averager: default (25-bit, N=4) and 8-bit, N=8 instances.
// Expected means follow WINDOW_AVERAGER_ROUND_EN when it is defined for the build.
module tb_window_averager;

`ifdef WINDOW_AVERAGER_ROUND_EN
  localparam logic [31:0] AVG_A1 = 32'd26;
  localparam logic [31:0] AVG_B1 = 32'd128;
  localparam logic [31:0] AVG_A5 = 32'd7;
`else
  localparam logic [31:0] AVG_A1 = 32'd25;
  localparam logic [31:0] AVG_B1 = 32'd127;
  localparam logic [31:0] AVG_A5 = 32'd6;
`endif
  localparam logic [31:0] ONES25 = 32'h01FF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;

  logic [24:0] rd_data_a;
  logic        rd_en_a, busy_a, done_a;
  logic [1:0]  rd_addr_a;
  logic [24:0] avg_a, min_a, max_a;

  logic [7:0]  rd_data_b;
  logic        rd_en_b, busy_b, done_b;
  logic [2:0]  rd_addr_b;
  logic [7:0]  avg_b, min_b, max_b;

  logic [24:0] mem_a [4];
  logic [7:0]  mem_b [8];

  logic [31:0] prev_avg [2];
  logic [31:0] prev_min [2];
  logic [31:0] prev_max [2];

  int n_tests = 0;
  int n_fail  = 0;

  window_averager #(.WIDTH(25), .LOG2_DEPTH(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rd_data(rd_data_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .busy(busy_a), .done(done_a),
    .avg(avg_a), .min(min_a), .max(max_a)
  );

  window_averager #(.WIDTH(8), .LOG2_DEPTH(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rd_data(rd_data_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .busy(busy_b), .done(done_b),
    .avg(avg_b), .min(min_b), .max(max_b)
  );

  always #5 clk = ~clk;

  // Synchronous-read buffers; off-strobe cycles present junk that must be ignored.
  always @(posedge clk) begin
    rd_data_a <= rd_en_a ? mem_a[rd_addr_a] : 25'($urandom);
    rd_data_b <= rd_en_b ? mem_b[rd_addr_b] : 8'($urandom);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_results(input int sel, input logic [31:0] ea, input logic [31:0] emn,
                             input logic [31:0] emx);
    chk("avg", 64'(sel != 0 ? 25'(avg_b) : avg_a), 64'(ea));
    chk("min", 64'(sel != 0 ? 25'(min_b) : min_a), 64'(emn));
    chk("max", 64'(sel != 0 ? 25'(max_b) : max_a), 64'(emx));
  endtask

  // Pulses start, then walks cycles 1..N+2 checking the handshake and results.
  // With raise set, start is asserted in the done cycle and the following idle cycle is checked.
  task automatic run_win(input int sel, input logic [31:0] ea, input logic [31:0] emn,
                         input logic [31:0] emx, input bit raise);
    int n;
    n = (sel != 0) ? 8 : 4;
    @(negedge clk);
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      chk("rd_en", 64'(sel != 0 ? rd_en_b : rd_en_a), 64'(c <= n));
      if (c <= n) chk("rd_addr", 64'(sel != 0 ? 3'(rd_addr_b) : 3'(rd_addr_a)), 64'(c - 1));
      chk("busy", 64'(sel != 0 ? busy_b : busy_a), 64'(c <= n + 1));
      chk("done", 64'(sel != 0 ? done_b : done_a), 64'(c == n + 2));
      if (c == n + 2) chk_results(sel, ea, emn, emx);
      else            chk_results(sel, prev_avg[sel], prev_min[sel], prev_max[sel]);
    end
    prev_avg[sel] = ea;
    prev_min[sel] = emn;
    prev_max[sel] = emx;
    if (raise) begin
      if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      chk("rd_en_after_done", 64'(sel != 0 ? rd_en_b : rd_en_a), 64'(0));
      chk("busy_after_done", 64'(sel != 0 ? busy_b : busy_a), 64'(0));
      chk("done_after_done", 64'(sel != 0 ? done_b : done_a), 64'(0));
    end
  endtask

  task automatic chk_reset_a();
    chk("rst_rd_en", 64'(rd_en_a), 64'(0));
    chk("rst_rd_addr", 64'(rd_addr_a), 64'(0));
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_done", 64'(done_a), 64'(0));
    chk_results(0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      prev_avg[i] = 32'd0;
      prev_min[i] = 32'd0;
      prev_max[i] = 32'd0;
    end
    mem_a[0] = 25'd10; mem_a[1] = 25'd20; mem_a[2] = 25'd30; mem_a[3] = 25'd42;
    mem_b[0] = 8'd0; mem_b[1] = 8'd255; mem_b[2] = 8'd1; mem_b[3] = 8'd254;
    mem_b[4] = 8'd2; mem_b[5] = 8'd253; mem_b[6] = 8'd3; mem_b[7] = 8'd252;

    #1 reset = 1'b1;
    #20;
    chk_reset_a();
    chk("rst_b_done", 64'(done_b), 64'(0));
    chk("rst_b_avg", 64'(avg_b), 64'(0));
    @(negedge clk) reset = 1'b0;

    run_win(0, AVG_A1, 32'd10, 32'd42, 1'b0);
    @(posedge clk);
    run_win(1, AVG_B1, 32'd0, 32'd255, 1'b0);

    for (int i = 0; i < 4; i++) mem_a[i] = 25'(ONES25);
    @(posedge clk);
    run_win(0, ONES25, ONES25, ONES25, 1'b0);
    mem_a[0] = 25'd10; mem_a[1] = 25'd20; mem_a[2] = 25'd30; mem_a[3] = 25'd42;
    @(posedge clk);
    run_win(0, AVG_A1, 32'd10, 32'd42, 1'b0);

    // start held high: windows repeat every N+3 = 7 cycles.
    @(posedge clk); #1;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      chk("hold_rd_en", 64'(rd_en_a), 64'(((c - 1) % 7) < 4));
      chk("hold_done", 64'(done_a), 64'((c % 7) == 6));
      if ((c % 7) == 6) chk("hold_avg", 64'(avg_a), 64'(AVG_A1));
    end
    start_a = 1'b0;

    // Reset in cycle 3 of a window aborts it and clears the held results.
    @(posedge clk); #1;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_reset_a();
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prev_avg[i] = 32'd0;
      prev_min[i] = 32'd0;
      prev_max[i] = 32'd0;
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 64'(done_a), 64'(0));
    end
    mem_a[0] = 25'd100; mem_a[1] = 25'd200; mem_a[2] = 25'd300; mem_a[3] = 25'd401;
    run_win(0, 32'd250, 32'd100, 32'd401, 1'b1);

    // start raised in the done cycle only takes effect one cycle later.
    mem_a[0] = 25'd5; mem_a[1] = 25'd6; mem_a[2] = 25'd7; mem_a[3] = 25'd9;
    run_win(0, AVG_A5, 32'd5, 32'd9, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
